alu_datapath: RTL
=================

// Module: alu_datapath
// PURPOSE
//  Operand/execute stage driven by the ALU control FSM. Captures operands A/B from the
//  instruction word on ldA/ldB and executes the one-cycle op strobes (cmp/add/sub/div/mul).
//  Add, sub and cmp are single-cycle. Mul (shift-add) and div (restoring) iterate over OPW cycles.
//  Produces a registered result, status flags and a done pulse. All arithmetic is unsigned.
// PARAMETERS
//  OPW  4           operand width; Datain width DW = 2*OPW+4 (12 at default)
// PORTS
//  clk      in   1      clock, rising edge
//  reset    in   1      asynchronous, active-low
//  Datain   in   DW     instruction word: [DW-1 -: OPW]=A, [DW-OPW-1 -: OPW]=B, [3:0] opcode (unused here)
//  ldA      in   1      load A from Datain
//  ldB      in   1      load B from Datain
//  aCmp     in   1      compare strobe (1 cycle)
//  aAdd     in   1      add strobe
//  aSub     in   1      subtract strobe
//  aDiv     in   1      divide strobe
//  aMul     in   1      multiply strobe
//  result   out  2*OPW  registered result
//  eq,lt,gt out  1 ea   compare flags (A vs B)
//  carry    out  1      add carry-out / sub borrow
//  dz       out  1      divide-by-zero
//  busy     out  1      multi-cycle op in progress
//  done     out  1      1-cycle pulse: result/flags valid
//  drop     out  1      1-cycle pulse: op strobe ignored because busy
// BEHAVIOUR
//  Reset (async, reset=0): every output, regA, regB, working regs and counter = 0; state=IDLE.
//  Operand load:
//   - ldA: regA<=Datain A field. ldB: regB<=Datain B field. Both may assert together.
//   - Loads are honoured in every state. A running mul/div uses its start-time copies.
//  States: IDLE, MUL_RUN, DIV_RUN.
//  Strobe priority (if several high): cmp > add > sub > div > mul. Only the winner executes.
//  Strobe in IDLE, sampled at edge k:
//   - cmp: eq/lt/gt <= (A==B, A<B, A>B); result<=0; done=1 after edge k.
//   - add: result <= zero-ext(A+B) (OPW+1 bits); carry<=sum[OPW]; done after edge k.
//   - sub: result <= zero-ext((A-B) mod 2^OPW); carry<=(A<B); done after edge k.
//   - mul: latch A,B; acc=0; cnt=OPW; ->MUL_RUN; busy=1 after edge k.
//   - div, B!=0: latch A,B; rem=0; cnt=OPW; dz<=0; ->DIV_RUN; busy=1 after edge k.
//   - div, B==0: result <= {A, {OPW{1'b1}}}; dz<=1; done after edge k; no busy.
//  MUL_RUN: one multiplier bit per edge (LSB first); after OPW edges (edge k+OPW):
//   - result<=A*B; state->IDLE; busy=0; done=1.
//  DIV_RUN: one restoring step per edge (MSB first); after edge k+OPW:
//   - result <= {remainder, quotient}; ->IDLE; busy=0; done=1.
//  Result/flag hold rules:
//   - Only the executing op updates its own flags. cmp: eq/lt/gt. add/sub: carry. div: dz.
//   - All other flags and result hold.
//  Strobe while busy (state != IDLE): ignored; drop=1 for the next cycle; running op unaffected.
//  Strobe in the cycle done=1 (state IDLE): accepted normally.
//  done and drop are single-cycle pulses; both 0 otherwise.
//  Reset mid-operation: immediate abort to reset values; no done pulse follows.
// TESTING (OPW=4)
//  1. ldA/ldB with Datain=12'h98_2, then aAdd -> result=8'h11, carry=1, done 1 cycle after strobe.
//  2. A=3, B=5; aSub -> result=8'h0E, carry=1. Then aCmp -> lt=1, eq=0, gt=0, result=0.
//  3. A=15, B=15; aMul -> busy for 4 cycles; done at edge k+4 with result=8'hE1.
//  4. A=13, B=4; aDiv -> done at k+4, result=8'h13 (rem 1, quo 3), dz=0.
//     Then B=0; aDiv -> done at k+1, result=8'hDF, dz=1.
//  5. aMul in flight; aAdd at k+2 and ldA at k+1 -> drop pulse; product uses original A; add not executed.
//  6. reset low at k+2 of an aDiv -> all outputs 0 immediately, busy=0, no done; next aAdd works.

Source files
------------

// File: rtl/alu_datapath_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : alu_datapath_if                                                |
// | Purpose   : Bundles the instruction word, load/op strobes and the result / |
// |             status outputs of the ALU operand/execute stage.               |
// | Modports  : master - drives Datain, ldA/ldB and op strobes; observes       |
// |                      result, flags, busy, done and drop.                   |
// |             slave  - the datapath side (directions reversed).              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface alu_datapath_if #(
   parameter int OPW = 4
);
   localparam int DW = 2*OPW + 4;

   logic [DW-1:0]    Datain;
   logic             ldA;
   logic             ldB;
   logic             aCmp;
   logic             aAdd;
   logic             aSub;
   logic             aDiv;
   logic             aMul;
   logic [2*OPW-1:0] result;
   logic             eq;
   logic             lt;
   logic             gt;
   logic             carry;
   logic             dz;
   logic             busy;
   logic             done;
   logic             drop;

   modport master (
      output Datain, ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul,
      input  result, eq, lt, gt, carry, dz, busy, done, drop
   );

   modport slave (
      input  Datain, ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul,
      output result, eq, lt, gt, carry, dz, busy, done, drop
   );
endinterface
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : alu_datapath                                                   |
// | Purpose   : Operand/execute stage of the ALU. Captures A/B from the        |
// |             instruction word and executes single-cycle cmp/add/sub and     |
// |             multi-cycle unsigned mul (shift-add) and div (restoring).      |
// | Ports     : clk   - clock, rising edge                                     |
// |             reset - asynchronous, active-low                               |
// |             bus   - alu_datapath_if.slave: Datain, ldA, ldB, aCmp, aAdd,   |
// |                     aSub, aDiv, aMul in; result, eq, lt, gt, carry, dz,    |
// |                     busy, done, drop out                                   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module alu_datapath #(
   parameter int OPW = 4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   alu_datapath_if.slave      bus
);
   localparam int DW = 2*OPW + 4;
   localparam int CW = $clog2(OPW + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MUL_RUN = 2'd1,
      S_DIV_RUN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [OPW-1:0]     regA_q, regA_d;
   logic [OPW-1:0]     regB_q, regB_d;
   logic [2*OPW-1:0]   mcand_q, mcand_d;    // multiplicand, shifted left each step
   logic [OPW-1:0]     mplier_q, mplier_d;  // multiplier, consumed LSB first
   logic [2*OPW-1:0]   acc_q, acc_d;
   logic [OPW-1:0]     divsr_q, divsr_d;    // divisor captured at start
   logic [OPW-1:0]     dvd_q, dvd_d;        // dividend bits out on top, quotient bits in at bottom
   logic [OPW-1:0]     rem_q, rem_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*OPW-1:0]   result_q, result_d;
   logic               eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
   logic               carry_q, carry_d, dz_q, dz_d;
   logic               busy_q, busy_d, done_q, done_d, drop_q, drop_d;

   logic [OPW-1:0]     w_datA, w_datB;
   logic               w_any;
   logic [OPW:0]       w_sum;
   logic [OPW-1:0]     w_diff;
   logic [2*OPW-1:0]   w_acc_nxt;
   logic [OPW:0]       w_trial, w_trial_sub;
   logic               w_ge;
   logic [OPW-1:0]     w_rem_nxt, w_dvd_nxt;
   logic               w_unused_opcode;

   assign w_datA          = bus.Datain[DW-1 -: OPW];
   assign w_datB          = bus.Datain[DW-OPW-1 -: OPW];
   assign w_unused_opcode = ^bus.Datain[3:0];
   assign w_any           = bus.aCmp | bus.aAdd | bus.aSub | bus.aDiv | bus.aMul;

   assign w_sum  = {1'b0, regA_q} + {1'b0, regB_q};
   assign w_diff = regA_q - regB_q;

   // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
   assign w_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Restoring step: bring down the next dividend bit, subtract when it fits.
   // The partial remainder stays below the divisor, so the trial value fits OPW+1 bits.
   assign w_trial     = {rem_q, dvd_q[OPW-1]};
   assign w_trial_sub = w_trial - {1'b0, divsr_q};
   assign w_ge        = (w_trial >= {1'b0, divsr_q});
   assign w_rem_nxt   = w_ge ? w_trial_sub[OPW-1:0] : w_trial[OPW-1:0];
   assign w_dvd_nxt   = {dvd_q[OPW-2:0], w_ge};

   always_comb begin
      state_d  = state_q;
      regA_d   = regA_q;
      regB_d   = regB_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      divsr_d  = divsr_q;
      dvd_d    = dvd_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      eq_d     = eq_q;
      lt_d     = lt_q;
      gt_d     = gt_q;
      carry_d  = carry_q;
      dz_d     = dz_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      drop_d   = 1'b0;

      // Operand loads are independent of the FSM; running ops use their own copies.
      if (bus.ldA) regA_d = w_datA;
      if (bus.ldB) regB_d = w_datB;

      case (state_q)
         S_IDLE: begin
            if (bus.aCmp) begin
               eq_d     = (regA_q == regB_q);
               lt_d     = (regA_q <  regB_q);
               gt_d     = (regA_q >  regB_q);
               result_d = '0;
               done_d   = 1'b1;
            end else if (bus.aAdd) begin
               result_d = {{(OPW-1){1'b0}}, w_sum};
               carry_d  = w_sum[OPW];
               done_d   = 1'b1;
            end else if (bus.aSub) begin
               result_d = {{OPW{1'b0}}, w_diff};
               carry_d  = (regA_q < regB_q);
               done_d   = 1'b1;
            end else if (bus.aDiv) begin
               if (regB_q == '0) begin
                  result_d = {regA_q, {OPW{1'b1}}};
                  dz_d     = 1'b1;
                  done_d   = 1'b1;
               end else begin
                  divsr_d = regB_q;
                  dvd_d   = regA_q;
                  rem_d   = '0;
                  cnt_d   = CW'(OPW);
                  dz_d    = 1'b0;
                  busy_d  = 1'b1;
                  state_d = S_DIV_RUN;
               end
            end else if (bus.aMul) begin
               mcand_d  = {{OPW{1'b0}}, regA_q};
               mplier_d = regB_q;
               acc_d    = '0;
               cnt_d    = CW'(OPW);
               busy_d   = 1'b1;
               state_d  = S_MUL_RUN;
            end
         end

         S_MUL_RUN: begin
            drop_d   = w_any;
            acc_d    = w_acc_nxt;
            mcand_d  = {mcand_q[2*OPW-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[OPW-1:1]};
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               result_d = w_acc_nxt;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end

         S_DIV_RUN: begin
            drop_d = w_any;
            rem_d  = w_rem_nxt;
            dvd_d  = w_dvd_nxt;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               result_d = {w_rem_nxt, w_dvd_nxt};
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         regA_q   <= '0;
         regB_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         divsr_q  <= '0;
         dvd_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         gt_q     <= 1'b0;
         carry_q  <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         regA_q   <= regA_d;
         regB_q   <= regB_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         divsr_q  <= divsr_d;
         dvd_q    <= dvd_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
         gt_q     <= gt_d;
         carry_q  <= carry_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         drop_q   <= drop_d;
      end
   end

   assign bus.result = result_q;
   assign bus.eq     = eq_q;
   assign bus.lt     = lt_q;
   assign bus.gt     = gt_q;
   assign bus.carry  = carry_q;
   assign bus.dz     = dz_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.drop   = drop_q;

endmodule
`default_nettype wire
